// File: rtl/ternary_divider_seq.sv
// Sequential balanced-ternary divider: converts to binary, restoring-divides the magnitudes, converts back.
// Optional macro TERNARY_DIV_INVALID_CHECK_EN flags operands that carry T_INVALID trits.
package ternary_pkg;
  typedef enum logic [1:0] {
    T_ZERO    = 2'b00,
    T_POS_ONE = 2'b01,
    T_NEG_ONE = 2'b10,
    T_INVALID = 2'b11
  } trit_t;
endpackage

module ternary_divider_seq
  import ternary_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  trit_t [WIDTH-1:0] dividend,
  input  trit_t [WIDTH-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output trit_t [WIDTH-1:0] quotient,
  output trit_t [WIDTH-1:0] remainder,
  output logic              div_zero,
  output logic              invalid
);

  localparam int MAX_MAG  = (3 ** WIDTH - 1) / 2;
  localparam int MAG_BITS = $clog2(MAX_MAG + 1);
  localparam int CNT_W    = $clog2(MAG_BITS);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CONV = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] PACK = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef trit_t [WIDTH-1:0] word_t;

  function automatic int trits_to_int(input word_t t);
    int acc;
    // NOTE: functions and always_comb use blocking '=' so each line sees the previous result.
    acc = 0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      acc = acc * 3;
      if (t[j] == T_POS_ONE) acc = acc + 1;
      else if (t[j] == T_NEG_ONE) acc = acc - 1;
    end
    return acc;
  endfunction

  // Digits of |v| are produced LSB first; a negative value is the same digits with +1/-1 swapped.
  function automatic word_t mag_to_trits(input logic [MAG_BITS-1:0] mag, input logic neg);
    word_t t;
    int    v;
    v = int'(mag);
    for (int j = 0; j < WIDTH; j++) begin
      case (v % 3)
        1:       begin t[j] = neg ? T_NEG_ONE : T_POS_ONE; v = v / 3;     end
        2:       begin t[j] = neg ? T_POS_ONE : T_NEG_ONE; v = v / 3 + 1; end
        default: begin t[j] = T_ZERO;                      v = v / 3;     end
      endcase
    end
    return t;
  endfunction

  function automatic word_t fill(input trit_t d);
    word_t t;
    for (int j = 0; j < WIDTH; j++) t[j] = d;
    return t;
  endfunction

  function automatic word_t sanitize(input word_t w);
    word_t t;
    for (int j = 0; j < WIDTH; j++) t[j] = (w[j] == T_INVALID) ? T_ZERO : w[j];
    return t;
  endfunction

  logic [2:0]          state;
  logic                captured;
  logic                armed;
  logic [CNT_W-1:0]    cnt;
  word_t               op_a, op_b;
  logic                sign_a, sign_b;
  logic [MAG_BITS-1:0] dsr, quo, rem;

  int                  a_val, b_val;
  logic [MAG_BITS-1:0] a_mag, b_mag, rem_next;
  logic [MAG_BITS:0]   shifted;
  logic                ge;
  logic                accept;

  // The accept edge only captures operands; CONV starts one cycle later. armed blocks the edge right after reset.
  assign in_ready  = (state == IDLE) && !captured;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && armed;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    a_val    = trits_to_int(op_a);
    b_val    = trits_to_int(op_b);
    a_mag    = MAG_BITS'(a_val < 0 ? -a_val : a_val);
    b_mag    = MAG_BITS'(b_val < 0 ? -b_val : b_val);
    shifted  = {rem, quo[MAG_BITS-1]};
    ge       = shifted >= {1'b0, dsr};
    rem_next = ge ? MAG_BITS'(shifted - {1'b0, dsr}) : shifted[MAG_BITS-1:0];
  end

`ifdef TERNARY_DIV_INVALID_CHECK_EN
  function automatic logic has_invalid(input word_t w);
    logic f;
    f = 1'b0;
    for (int j = 0; j < WIDTH; j++) f = f | (w[j] == T_INVALID);
    return f;
  endfunction

  logic op_invalid;
  always_comb op_invalid = has_invalid(op_a) || has_invalid(op_b);
`else
  assign invalid = 1'b0;
`endif

  // NOTE: datapath registers are always loaded before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= dividend;
      op_b <= divisor;
    end
    case (state)
      CONV: begin
        dsr    <= b_mag;
        quo    <= a_mag;
        rem    <= '0;
        sign_a <= a_val < 0;
        sign_b <= b_val < 0;
      end
      ITER: begin
        quo <= {quo[MAG_BITS-2:0], ge};
        rem <= rem_next;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      captured  <= 1'b0;
      armed     <= 1'b0;
      cnt       <= '0;
      quotient  <= fill(T_ZERO);
      remainder <= fill(T_ZERO);
      div_zero  <= 1'b0;
`ifdef TERNARY_DIV_INVALID_CHECK_EN
      invalid   <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (captured) begin
            captured <= 1'b0;
            state    <= CONV;
          end else if (accept) begin
            captured <= 1'b1;
          end
        end
        CONV: begin
`ifdef TERNARY_DIV_INVALID_CHECK_EN
          if (op_invalid) begin
            quotient  <= fill(T_INVALID);
            remainder <= fill(T_INVALID);
            div_zero  <= 1'b0;
            invalid   <= 1'b1;
            state     <= DONE;
          end else
`endif
          if (b_val == 0) begin
            quotient  <= fill(T_ZERO);
            remainder <= sanitize(op_a);
            div_zero  <= 1'b1;
`ifdef TERNARY_DIV_INVALID_CHECK_EN
            invalid   <= 1'b0;
`endif
            state     <= DONE;
          end else begin
            cnt   <= CNT_W'(MAG_BITS - 1);
            state <= ITER;
          end
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= PACK;
        end
        PACK: begin
          quotient  <= mag_to_trits(quo, sign_a ^ sign_b);
          remainder <= mag_to_trits(rem, sign_a);
          div_zero  <= 1'b0;
`ifdef TERNARY_DIV_INVALID_CHECK_EN
          invalid   <= 1'b0;
`endif
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ternary_divider_seq.md
TERNARY_DIVIDER_SEQ -- requirements
Module: ternary_divider_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: trits per operand. It SHALL derive localparam MAG_BITS = 12 for WIDTH=8, sized to hold (3^WIDTH-1)/2.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: operand pair present.
REQ-005 SHALL have port in_ready, output, 1: block idle and able to accept operands.
REQ-006 SHALL have port dividend, input, trit_t [WIDTH-1:0]: balanced-ternary dividend (ternary_pkg encoding).
REQ-007 SHALL have port divisor, input, trit_t [WIDTH-1:0]: balanced-ternary divisor.
REQ-008 SHALL have port out_valid, output, 1: result present.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port quotient, output, trit_t [WIDTH-1:0]: balanced-ternary quotient.
REQ-011 SHALL have port remainder, output, trit_t [WIDTH-1:0]: balanced-ternary remainder.
REQ-012 SHALL have port div_zero, output, 1: divisor value was 0.
REQ-013 SHALL have port invalid, output, 1: an operand contained T_INVALID. Driven only under REQ-031; tied 0 otherwise.

Function
REQ-014 SHALL compute truncating signed division: quotient = trunc(A/B), remainder = A - B*quotient. The remainder sign SHALL follow the dividend, with |remainder| < |B|.
REQ-015 SHALL accept operands on the edge where in_valid && in_ready. It SHALL register the operands internally and drop in_ready on the following cycle.
REQ-016 SHALL implement FSM states IDLE, CONV, ITER, PACK, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0. On accept SHALL go to CONV.
REQ-018 CONV, 1 cycle: SHALL convert both operands to signed integers (trit weight 3^j) and latch the magnitudes and signs.
REQ-019 CONV -> ITER if the divisor is nonzero. Otherwise CONV -> DONE with quotient all T_ZERO, remainder = dividend, div_zero=1.
REQ-020 ITER: SHALL perform exactly MAG_BITS cycles of binary restoring division on the magnitudes, one quotient bit per cycle. A counter SHALL run MAG_BITS-1 down to 0, then the FSM SHALL go to PACK.
REQ-021 PACK, 1 cycle: SHALL apply signs and convert quotient and remainder to balanced ternary, registered, then go to DONE.
REQ-022 DONE: out_valid=1. quotient, remainder, div_zero and invalid SHALL be stable while out_valid && !out_ready.
REQ-023 DONE: out_valid && out_ready SHALL go to IDLE, and out_valid SHALL be 0 the next cycle.
REQ-024 Latency: for an accept on edge k with nonzero divisor, out_valid SHALL rise after edge k+15 for WIDTH=8 (MAG_BITS+3). For a zero divisor, out_valid SHALL rise after edge k+2.
REQ-025 in_ready SHALL stay 0 in CONV, ITER, PACK and DONE. No new operands SHALL be accepted in the same cycle the result is consumed; the earliest next accept is the cycle after DONE exits.
REQ-026 Overflow cannot occur: |quotient| <= |A|, so every result SHALL be representable in WIDTH trits.
REQ-027 Output trits SHALL only ever be T_ZERO, T_POS_ONE or T_NEG_ONE, except under REQ-031.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously go to IDLE with in_ready=1, out_valid=0, div_zero=0, invalid=0, quotient and remainder all T_ZERO, and the iteration counter at 0.
REQ-029 rst_n asserted mid-operation (any state) SHALL abort the operation with no output handshake. The first accept after deassertion SHALL start a fresh operation.
REQ-030 Deassertion SHALL take effect on the first rising clk edge after rst_n returns high. No operand SHALL be accepted on that same edge.

Configuration
REQ-031 Macro TERNARY_DIV_INVALID_CHECK_EN:
- Defined: any T_INVALID trit in either captured operand SHALL set invalid=1 and send CONV -> DONE with quotient and remainder all T_INVALID. This check SHALL take priority over div_zero.
- Undefined: T_INVALID SHALL be weighted as 0 in conversion, and invalid SHALL be tied 0.

Verification
REQ-032 dividend=100, divisor=7 -> quotient=14, remainder=2, div_zero=0, out_valid after 15 cycles.
REQ-033 dividend=-100, divisor=7 -> quotient=-14, remainder=-2. Then dividend=3280, divisor=-1 -> quotient=-3280, remainder=0.
REQ-034 dividend=5, divisor=0 -> div_zero=1, quotient=0, remainder=5, out_valid after 2 cycles.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low at ITER cycle 5 -> out_valid never asserts. Next op 81/-9 -> quotient=-9, remainder=0.
REQ-037 With TERNARY_DIV_INVALID_CHECK_EN defined, divisor trit 3 = T_INVALID -> invalid=1, outputs all T_INVALID.
